// File: rtl/vsm_pkg.sv
// Shared definitions for the VSM sequencer: opcodes, FSM states and the
// control-word layout produced by the decoder.
package vsm_pkg;

  // Opcode field values (instruction bits [7:4]). Values 8..F are unused
  // and execute as NOP, so these are plain constants rather than an enum.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  localparam int unsigned PC_W    = 4;
  localparam int unsigned INSTR_W = 8;

  // Sequencer states: every instruction is FETCH then EXEC; HALT is sticky.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // How the program counter moves at the closing edge of the current cycle.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2
  } pc_sel_t;

  // Datapath control word driven towards the arithmetic unit and registers.
  typedef struct packed {
    logic add_sub;
    logic en_alu;
    logic en_imm;
    logic load_a;
    logic load_b;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Extract the opcode field of an instruction word.
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[7:4];
  endfunction

endpackage

// File: rtl/vsm_decode.sv
// Purely combinational opcode decoder: turns the latched instruction and the
// current state into datapath controls and sequencing requests.
import vsm_pkg::*;

module vsm_decode (
  input  state_t             state,
  input  logic [INSTR_W-1:0] ir,
  input  logic               carry_flag,
  output ctrl_t              ctrl,
  output pc_sel_t            pc_sel,
  output logic               upd_carry,
  output logic               go_halt
);

  logic [3:0] opcode;

  assign opcode = opcode_of(ir);

  // Decode controls; only EXEC produces any activity, FETCH/HALT stay idle.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    ctrl      = CTRL_IDLE;
    pc_sel    = PC_HOLD;
    upd_carry = 1'b0;
    go_halt   = 1'b0;

    if (state == S_EXEC) begin
      pc_sel = PC_INC;
      case (opcode)
        OP_LDA: begin
          ctrl.en_imm = 1'b1;
          ctrl.load_a = 1'b1;
        end
        OP_LDB: begin
          ctrl.en_imm = 1'b1;
          ctrl.load_b = 1'b1;
        end
        OP_ADD: begin
          ctrl.en_alu = 1'b1;
          ctrl.load_a = 1'b1;
          upd_carry   = 1'b1;
        end
        OP_SUB: begin
          ctrl.add_sub = 1'b1;
          ctrl.en_alu  = 1'b1;
          ctrl.load_a  = 1'b1;
          upd_carry    = 1'b1;
        end
        OP_JMP: pc_sel = PC_JUMP;
        OP_JC:  pc_sel = carry_flag ? PC_JUMP : PC_INC;
        OP_HALT: begin
          pc_sel  = PC_HOLD;
          go_halt = 1'b1;
        end
        // OP_NOP and the unused opcodes 8..F just advance the PC.
        default: pc_sel = PC_INC;
      endcase
    end
  end

endmodule

// File: rtl/vsm_sequencer.sv
// Two-cycle fetch/execute sequencer for a 4-bit accumulator machine. Holds the
// FSM state, program counter, instruction register and carry flag; all
// outputs derive from registered state, never directly from Instr or Carry.
import vsm_pkg::*;

module vsm_sequencer (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Carry,
  output logic [PC_W-1:0]    Pc,
  output logic               AddSub,
  output logic               EnableAlu,
  output logic               EnableImm,
  output logic [3:0]         ImmData,
  output logic               LoadA,
  output logic               LoadB,
  output logic               CarryFlag,
  output logic               Halted
);

  state_t             state;
  state_t             state_next;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               carry_flag_q;

  ctrl_t   dec_ctrl;
  pc_sel_t dec_pc_sel;
  logic    dec_upd_carry;
  logic    dec_go_halt;

  vsm_decode u_decode (
    .state      (state),
    .ir         (ir_q),
    .carry_flag (carry_flag_q),
    .ctrl       (dec_ctrl),
    .pc_sel     (dec_pc_sel),
    .upd_carry  (dec_upd_carry),
    .go_halt    (dec_go_halt)
  );

  // State register; a synchronous Reset returns to FETCH from any state.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: FETCH always moves to EXEC, EXEC returns to FETCH unless
  // the instruction is HALT, and HALT is left only through Reset.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = S_EXEC;
      S_EXEC:  state_next = dec_go_halt ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Architectural registers: IR captures in FETCH, PC and carry flag update
  // at the end of EXEC. Reset wins over any pending EXEC update.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q         <= '0;
      ir_q         <= '0;
      carry_flag_q <= 1'b0;
    end else begin
      if (state == S_FETCH) begin
        ir_q <= Instr;
      end
      if (dec_upd_carry) begin
        carry_flag_q <= Carry;
      end
      case (dec_pc_sel)
        PC_INC:  pc_q <= pc_q + 4'd1;  // 4-bit add wraps 15 -> 0
        PC_JUMP: pc_q <= ir_q[3:0];
        default: pc_q <= pc_q;
      endcase
    end
  end

  // Controls are forced idle while Reset is high so an interrupted EXEC
  // cannot load A/B in the reset cycle.
  always_comb begin
    AddSub    = 1'b0;
    EnableAlu = 1'b0;
    EnableImm = 1'b0;
    LoadA     = 1'b0;
    LoadB     = 1'b0;
    Halted    = 1'b0;
    if (!Reset) begin
      AddSub    = dec_ctrl.add_sub;
      EnableAlu = dec_ctrl.en_alu;
      EnableImm = dec_ctrl.en_imm;
      LoadA     = dec_ctrl.load_a;
      LoadB     = dec_ctrl.load_b;
      Halted    = (state == S_HALT);
    end
  end

  assign Pc        = pc_q;
  assign ImmData   = ir_q[3:0];
  assign CarryFlag = carry_flag_q;

endmodule

// File: tb/tb_vsm_sequencer.sv
// Self-checking bench for vsm_sequencer: a table of per-cycle expectations for
// the basic program, hand-written corner sequences, and a randomized run
// checked every cycle against an instruction-level reference model.
module tb_vsm_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic       carry;
  logic [3:0] pc;
  logic       add_sub;
  logic       en_alu;
  logic       en_imm;
  logic [3:0] imm_data;
  logic       load_a;
  logic       load_b;
  logic       carry_flag;
  logic       halted;

  logic [7:0] prog [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = fetch, 1 = execute, 2 = halted.
  int         m_phase = 0;
  logic [3:0] m_pc    = 4'd0;
  logic [7:0] m_ir    = 8'd0;
  logic       m_cf    = 1'b0;

  vsm_sequencer dut (
    .Clock     (clk),
    .Reset     (rst),
    .Instr     (instr),
    .Carry     (carry),
    .Pc        (pc),
    .AddSub    (add_sub),
    .EnableAlu (en_alu),
    .EnableImm (en_imm),
    .ImmData   (imm_data),
    .LoadA     (load_a),
    .LoadB     (load_b),
    .CarryFlag (carry_flag),
    .Halted    (halted)
  );

  // Program memory is addressed by the design's own PC.
  assign instr = prog[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assert property (@(posedge clk) !(en_alu && en_imm))
    else $error("FAIL alu_imm_overlap: EnableAlu and EnableImm both high");

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected {AddSub, EnableAlu, EnableImm, LoadA, LoadB} from the model.
  function automatic logic [4:0] model_ctrl();
    logic [3:0] op;
    op = m_ir[7:4];
    if (rst || m_phase != 1) return 5'b00000;
    case (op)
      4'h1:    return 5'b00110;
      4'h2:    return 5'b00101;
      4'h3:    return 5'b01010;
      4'h4:    return 5'b11010;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] dut_ctrl();
    return {add_sub, en_alu, en_imm, load_a, load_b};
  endfunction

  task automatic model_check();
    check("m_pc",      8'(pc),         8'(m_pc));
    check("m_imm",     8'(imm_data),   8'(m_ir[3:0]));
    check("m_ctrl",    8'(dut_ctrl()), 8'(model_ctrl()));
    check("m_halted",  8'(halted),     8'((m_phase == 2) && !rst));
    check("m_cflag",   8'(carry_flag), 8'(m_cf));
    check("m_excl",    8'(en_alu & en_imm), 8'd0);
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_update();
    logic [7:0] w;
    logic [3:0] op;
    logic [3:0] opr;
    w = prog[m_pc];
    if (rst) begin
      m_phase = 0;
      m_pc    = 4'd0;
      m_ir    = 8'd0;
      m_cf    = 1'b0;
    end else if (m_phase == 0) begin
      m_ir    = w;
      m_phase = 1;
    end else if (m_phase == 1) begin
      op      = m_ir[7:4];
      opr     = m_ir[3:0];
      m_phase = 0;
      if (op == 4'h7) begin
        m_phase = 2;
      end else if (op == 4'h5) begin
        m_pc = opr;
      end else if (op == 4'h6) begin
        m_pc = m_cf ? opr : 4'((m_pc + 1) % 16);
      end else begin
        if (op == 4'h3 || op == 4'h4) m_cf = carry;
        m_pc = 4'((m_pc + 1) % 16);
      end
    end
  endtask

  // Apply inputs for the current cycle (called right after a falling edge)
  // and compare against the model once outputs have settled.
  task automatic drive(input logic r, input logic c);
    rst   = r;
    carry = c;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic load_and_reset(input logic [7:0] p0, input logic [7:0] p1,
                                input int a1, input logic [7:0] v1);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = p0;
    prog[1] = p1;
    if (a1 >= 0) prog[a1] = v1;
    rst   = 1'b1;
    carry = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       rst;
    logic       carry;
    logic [3:0] pc;
    logic [3:0] imm;
    logic [4:0] ctrl;
    logic       halted;
    logic       cf;
  } vec_t;

  vec_t tbl [11];

  initial begin
    rst   = 1'b1;
    carry = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    @(negedge clk);

    // Basic program: LDA 3, LDB 5, ADD, HALT; Carry high during ADD EXEC.
    tbl[0]  = '{1'b1, 1'b0, 4'd0, 4'd0, 5'b00000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, 4'd0, 5'b00000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, 4'd3, 5'b00110, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'd1, 4'd3, 5'b00000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'd1, 4'd5, 5'b00101, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'd2, 4'd5, 5'b00000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'd2, 4'd0, 5'b01010, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'd3, 4'd0, 5'b00000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'd3, 4'd0, 5'b00000, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'd3, 4'd0, 5'b00000, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'd3, 4'd0, 5'b00000, 1'b1, 1'b1};

    load_and_reset(8'h13, 8'h25, 2, 8'h30);
    prog[3] = 8'h70;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].carry);
      check($sformatf("tbl%0d_pc", i),     8'(pc),         8'(tbl[i].pc));
      check($sformatf("tbl%0d_imm", i),    8'(imm_data),   8'(tbl[i].imm));
      check($sformatf("tbl%0d_ctrl", i),   8'(dut_ctrl()), 8'(tbl[i].ctrl));
      check($sformatf("tbl%0d_halted", i), 8'(halted),     8'(tbl[i].halted));
      check($sformatf("tbl%0d_cf", i),     8'(carry_flag), 8'(tbl[i].cf));
      tick();
    end

    // SUB with Carry=1 sets the flag; the following JC 9 is taken.
    load_and_reset(8'h41, 8'h69, -1, 8'h00);
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b1);
    check("sub_addsub", 8'(add_sub), 8'd1);
    check("sub_enalu",  8'(en_alu),  8'd1);
    tick();
    drive(1'b0, 1'b0);
    check("sub_cflag", 8'(carry_flag), 8'd1);
    check("sub_pc",    8'(pc),         8'd1);
    tick();
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0);
    check("jc_taken_pc", 8'(pc), 8'd9);
    tick();

    // JC 9 at Pc=4 with CarryFlag=0 falls through to 5.
    load_and_reset(8'h54, 8'h00, 4, 8'h69);
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b1); tick();
    drive(1'b0, 1'b0);
    check("jmp_pc", 8'(pc), 8'd4);
    tick();
    drive(1'b0, 1'b1); tick();
    drive(1'b0, 1'b0);
    check("jc_not_taken_pc", 8'(pc), 8'd5);
    tick();

    // NOP wrap 14 -> 15 -> 0 -> 1, with opcode B at 15 behaving as NOP.
    load_and_reset(8'h5E, 8'h00, 15, 8'hB0);
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0);
    check("wrap_pc14", 8'(pc), 8'd14);
    prog[0] = 8'h00;
    tick();
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0);
    check("wrap_pc15", 8'(pc), 8'd15);
    tick();
    drive(1'b0, 1'b1);
    check("opB_ctrl", 8'(dut_ctrl()), 8'd0);
    tick();
    drive(1'b0, 1'b0);
    check("wrap_pc0", 8'(pc), 8'd0);
    tick();
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0);
    check("wrap_pc1", 8'(pc), 8'd1);
    tick();

    // Reset during ADD EXEC: no load, no flag update, clean restart.
    load_and_reset(8'h30, 8'h00, -1, 8'h00);
    drive(1'b0, 1'b0); tick();
    drive(1'b1, 1'b1);
    check("rst_exec_ctrl", 8'(dut_ctrl()), 8'd0);
    tick();
    drive(1'b0, 1'b0);
    check("rst_exec_cf",   8'(carry_flag), 8'd0);
    check("rst_exec_pc",   8'(pc),         8'd0);
    check("rst_exec_ctrl2", 8'(dut_ctrl()), 8'd0);
    tick();

    // HALT is sticky until Reset.
    load_and_reset(8'h70, 8'h00, -1, 8'h00);
    drive(1'b0, 1'b0); tick();
    drive(1'b0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)));
      check("halt_sticky", 8'(halted), 8'd1);
      check("halt_pc",     8'(pc),     8'd0);
      tick();
    end
    drive(1'b1, 1'b0); tick();
    drive(1'b0, 1'b0);
    check("halt_exit", 8'(halted), 8'd0);
    tick();

    // Randomized programs, carries and occasional resets.
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
        drive(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
